// File: rtl/jtcontra_vtimer.sv
// Video timing generator: pixel/line counters with zero-lag blanking and sync flags.
// Define JTCONTRA_VTIMER_ADJ_EN to add frame-sampled signed HS/VS position offsets.
module jtcontra_vtimer #(
  parameter int HTOTAL   = 384,
  parameter int HB_START = 256,
  parameter int HS_START = 296,
  parameter int HS_LEN   = 32,
  parameter int VTOTAL   = 264,
  parameter int VB_START = 240,
  parameter int VB_END   = 16,
  parameter int VS_START = 248,
  parameter int VS_LEN   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  output logic [8:0] hdump,
  output logic [8:0] vdump,
  output logic [8:0] vrender,
  output logic [8:0] vrender1,
  output logic       LHBL,
  output logic       LVBL,
  output logic       HS,
  output logic       VS
`ifdef JTCONTRA_VTIMER_ADJ_EN
  ,
  input  logic [3:0] hoffset,
  input  logic [3:0] voffset
`endif
);

  localparam int unsigned W = 9;
  localparam logic [W-1:0] H_LAST = W'(HTOTAL - 1);
  localparam logic [W-1:0] V_LAST = W'(VTOTAL - 1);
  localparam logic [W-1:0] HB_S   = W'(HB_START);
  localparam logic [W-1:0] VB_S   = W'(VB_START);
  localparam logic [W-1:0] VB_E   = W'(VB_END);

  logic         h_last, v_last, frame_wrap;
  logic [W-1:0] h_nxt, v_nxt, vr_nxt, vr1_nxt;
  logic         lhbl_nxt, lvbl_nxt, hs_nxt, vs_nxt;
  logic [3:0]   hoff_c, voff_c;

  function automatic logic [W-1:0] inc_line(input logic [W-1:0] x);
    return (x == V_LAST) ? '0 : x + W'(1);
  endfunction

  // True when pos lies in the window [start, start+len) taken modulo total
  function automatic logic in_win(input logic [W-1:0] pos, input int start,
                                  input int len, input int total);
    int p, s, d;
    p = int'(pos);
    s = start;
    if (s < 0) s = s + total;
    else if (s >= total) s = s - total;
    d = (p >= s) ? p - s : p + total - s;
    return d < len;
  endfunction

  assign h_last     = (hdump == H_LAST);
  assign v_last     = (vdump == V_LAST);
  assign frame_wrap = h_last & v_last;

`ifdef JTCONTRA_VTIMER_ADJ_EN
  logic [3:0] hoff_q, voff_q;

  // New offsets take effect on the first pixel of the frame they were sampled for
  assign hoff_c = frame_wrap ? hoffset : hoff_q;
  assign voff_c = frame_wrap ? voffset : voff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hoff_q <= '0;
      voff_q <= '0;
    end else if (pxl_cen) begin
      hoff_q <= hoff_c;
      voff_q <= voff_c;
    end
  end
`else
  assign hoff_c = '0;
  assign voff_c = '0;
`endif

  // Next counter values; flags are derived from these so they register in step
  always_comb begin
    h_nxt   = h_last ? '0 : hdump + W'(1);
    v_nxt   = vdump;
    vr_nxt  = vrender;
    vr1_nxt = vrender1;
    if (h_last) begin
      v_nxt   = inc_line(vdump);
      vr_nxt  = inc_line(vrender);
      vr1_nxt = inc_line(vrender1);
    end
    lhbl_nxt = (h_nxt < HB_S);
    lvbl_nxt = (v_nxt >= VB_E) && (v_nxt < VB_S);
    hs_nxt   = in_win(h_nxt, HS_START + int'($signed(hoff_c)), HS_LEN, HTOTAL);
    vs_nxt   = in_win(v_nxt, VS_START + int'($signed(voff_c)), VS_LEN, VTOTAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdump    <= '0;
      vdump    <= '0;
      vrender  <= W'(1);
      vrender1 <= W'(2);
      LHBL     <= 1'b1;
      LVBL     <= 1'b0;
      HS       <= 1'b0;
      VS       <= 1'b0;
    end else if (pxl_cen) begin
      hdump    <= h_nxt;
      vdump    <= v_nxt;
      vrender  <= vr_nxt;
      vrender1 <= vr1_nxt;
      LHBL     <= lhbl_nxt;
      LVBL     <= lvbl_nxt;
      HS       <= hs_nxt;
      VS       <= vs_nxt;
    end
  end

endmodule

// File: tb/tb_jtcontra_vtimer.sv
// Bench for jtcontra_vtimer: a default-size and a small-frame instance share stimulus
// and are checked against a pixel-count reference model every clock.
module tb_jtcontra_vtimer;

  typedef struct {
    int ht, hb, hss, hsl, vt, vbs, vbe, vss, vsl;
  } tp_t;

  logic       clk = 1'b0;
  bit         clk_run = 1'b1;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic [3:0] hoffset = 4'h0;
  logic [3:0] voffset = 4'h0;

  logic [8:0] hdump_d, vdump_d, vrender_d, vrender1_d;
  logic       lhbl_d, lvbl_d, hs_d, vs_d;
  logic [8:0] hdump_s, vdump_s, vrender_s, vrender1_s;
  logic       lhbl_s, lvbl_s, hs_s, vs_s;

  tp_t pd, ps;
  int  n, ho_d, vo_d, ho_s, vo_s;
  int  checks = 0;
  int  errors = 0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  jtcontra_vtimer dut_d (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
    .hdump(hdump_d), .vdump(vdump_d), .vrender(vrender_d), .vrender1(vrender1_d),
    .LHBL(lhbl_d), .LVBL(lvbl_d), .HS(hs_d), .VS(vs_d)
`ifdef JTCONTRA_VTIMER_ADJ_EN
    , .hoffset(hoffset), .voffset(voffset)
`endif
  );

  jtcontra_vtimer #(
    .HTOTAL(48), .HB_START(32), .HS_START(44), .HS_LEN(8),
    .VTOTAL(24), .VB_START(20), .VB_END(2), .VS_START(22), .VS_LEN(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
    .hdump(hdump_s), .vdump(vdump_s), .vrender(vrender_s), .vrender1(vrender1_s),
    .LHBL(lhbl_s), .LVBL(lvbl_s), .HS(hs_s), .VS(vs_s)
`ifdef JTCONTRA_VTIMER_ADJ_EN
    , .hoffset(hoffset), .voffset(voffset)
`endif
  );

  // Expected outputs after n enabled pixels since reset, with the frame's offsets
  function automatic logic [39:0] model(input tp_t p, input int cnt, input int ho, input int vo);
    int h, v;
    logic hs, vs;
    if (cnt == 0) return {9'd0, 9'd0, 9'd1, 9'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    h  = cnt % p.ht;
    v  = (cnt / p.ht) % p.vt;
    hs = (((h - p.hss - ho) % p.ht + p.ht) % p.ht) < p.hsl;
    vs = (((v - p.vss - vo) % p.vt + p.vt) % p.vt) < p.vsl;
    return {9'(h), 9'(v), 9'((v + 1) % p.vt), 9'((v + 2) % p.vt),
            (h < p.hb), (v >= p.vbe && v < p.vbs), hs, vs};
  endfunction

  function automatic int sx(input logic [3:0] x);
    return int'($signed(x));
  endfunction

  function automatic logic [39:0] obs_d();
    return {hdump_d, vdump_d, vrender_d, vrender1_d, lhbl_d, lvbl_d, hs_d, vs_d};
  endfunction

  function automatic logic [39:0] obs_s();
    return {hdump_s, vdump_s, vrender_s, vrender1_s, lhbl_s, lvbl_s, hs_s, vs_s};
  endfunction

  task automatic step(input bit cen);
    pxl_cen = cen;
    @(posedge clk);
    #1;
    if (cen && rst_n) begin
      n++;
      if (n % (pd.ht * pd.vt) == 0) begin ho_d = sx(hoffset); vo_d = sx(voffset); end
      if (n % (ps.ht * ps.vt) == 0) begin ho_s = sx(hoffset); vo_s = sx(voffset); end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    n = 0; ho_d = 0; vo_d = 0; ho_s = 0; vo_s = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 60; i++) step($urandom_range(0, 1) == 1);
    clk_run = 1'b0;
    rst_n = 1'b0;
    #2;
    if (obs_d() !== model(pd, 0, 0, 0)) begin
      errors++; $display("FAIL reset_d got=%h exp=%h", obs_d(), model(pd, 0, 0, 0));
    end
    checks++;
    if (obs_s() !== model(ps, 0, 0, 0)) begin
      errors++; $display("FAIL reset_s got=%h exp=%h", obs_s(), model(ps, 0, 0, 0));
    end
    checks++;
    #20;
    rst_n = 1'b1;
    n = 0; ho_d = 0; vo_d = 0; ho_s = 0; vo_s = 0;
    #2;
    clk_run = 1'b1;
    step(1'b0);
  endtask

  task automatic test_line();
    int lhbl_fall, hs_first, hs_last;
    logic [17:0] hv_384;
    lhbl_fall = -1; hs_first = -1; hs_last = -1; hv_384 = '1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'b1);
      if (obs_d() !== model(pd, n, ho_d, vo_d)) begin
        errors++; $display("FAIL line_d n=%0d got=%h exp=%h", n, obs_d(), model(pd, n, ho_d, vo_d));
      end
      checks++;
      if (obs_s() !== model(ps, n, ho_s, vo_s)) begin
        errors++; $display("FAIL line_s n=%0d got=%h exp=%h", n, obs_s(), model(ps, n, ho_s, vo_s));
      end
      checks++;
      if (!lhbl_d && lhbl_fall < 0) lhbl_fall = int'(hdump_d);
      if (hs_d && vdump_d == 9'd0) begin
        if (hs_first < 0) hs_first = int'(hdump_d);
        hs_last = int'(hdump_d);
      end
      if (n == 384) hv_384 = {hdump_d, vdump_d};
    end
    if (lhbl_fall !== 256) begin errors++; $display("FAIL lhbl_fall got=%0d exp=256", lhbl_fall); end
    checks++;
    if (hs_first !== 296 || hs_last !== 327) begin
      errors++; $display("FAIL hs_window got=%0d..%0d exp=296..327", hs_first, hs_last);
    end
    checks++;
    if (hv_384 !== {9'd0, 9'd1}) begin
      errors++; $display("FAIL line_wrap got h/v=%h exp=%h", hv_384, {9'd0, 9'd1});
    end
    checks++;
  endtask

  task automatic test_gating();
    logic [39:0] prev;
    do_reset();
    for (int i = 0; i < 1600; i++) begin
      prev = obs_d();
      step(i % 4 == 3);
      if (obs_d() !== model(pd, n, ho_d, vo_d)) begin
        errors++; $display("FAIL gate_d n=%0d got=%h exp=%h", n, obs_d(), model(pd, n, ho_d, vo_d));
      end
      checks++;
      if (obs_s() !== model(ps, n, ho_s, vo_s)) begin
        errors++; $display("FAIL gate_s n=%0d got=%h exp=%h", n, obs_s(), model(ps, n, ho_s, vo_s));
      end
      checks++;
      if (i % 4 != 3) begin
        if (obs_d() !== prev) begin
          errors++; $display("FAIL gate_hold i=%0d got=%h exp=%h", i, obs_d(), prev);
        end
        checks++;
      end
    end
  endtask

  task automatic test_frame();
    int fs;
    logic [23:0] lvbl_mask, vs_mask;
    fs = ps.ht * ps.vt;
    lvbl_mask = '0; vs_mask = '0;
    do_reset();
    for (int i = 0; i < 4 * fs && n < fs; i++) begin
      step($urandom_range(0, 3) != 0);
      if (obs_s() !== model(ps, n, ho_s, vo_s)) begin
        errors++; $display("FAIL frame_s n=%0d got=%h exp=%h", n, obs_s(), model(ps, n, ho_s, vo_s));
      end
      checks++;
      if (n < fs) begin
        if (lvbl_s) lvbl_mask[int'(vdump_s)] = 1'b1;
        if (vs_s) vs_mask[int'(vdump_s)] = 1'b1;
      end
    end
    if (n != fs) begin errors++; $display("FAIL frame_timeout got n=%0d exp=%0d", n, fs); end
    checks++;
    if (lvbl_mask !== 24'h0FFFFC) begin
      errors++; $display("FAIL lvbl_lines got=%h exp=%h", lvbl_mask, 24'h0FFFFC);
    end
    checks++;
    if (vs_mask !== 24'hC00003) begin
      errors++; $display("FAIL vs_lines got=%h exp=%h", vs_mask, 24'hC00003);
    end
    checks++;
    if ({hdump_s, vdump_s, vrender_s, vrender1_s} !== {9'd0, 9'd0, 9'd1, 9'd2}) begin
      errors++; $display("FAIL frame_end got=%h exp=%h",
                         {hdump_s, vdump_s, vrender_s, vrender1_s}, {9'd0, 9'd0, 9'd1, 9'd2});
    end
    checks++;
  endtask

  task automatic test_wrap();
    bit seen_m2, seen_m1;
    seen_m2 = 1'b0; seen_m1 = 1'b0;
    for (int i = 0; i < 2 * ps.ht * ps.vt && !(seen_m1 && seen_m2); i++) begin
      step(1'b1);
      if (obs_s() !== model(ps, n, ho_s, vo_s)) begin
        errors++; $display("FAIL wrap_s n=%0d got=%h exp=%h", n, obs_s(), model(ps, n, ho_s, vo_s));
      end
      checks++;
      if (vdump_s == 9'd22 && !seen_m2) begin
        seen_m2 = 1'b1;
        if (vrender1_s !== 9'd0) begin
          errors++; $display("FAIL wrap_vr1_m2 got=%0d exp=0", vrender1_s);
        end
        checks++;
      end
      if (vdump_s == 9'd23 && !seen_m1) begin
        seen_m1 = 1'b1;
        if ({vrender_s, vrender1_s} !== {9'd0, 9'd1}) begin
          errors++; $display("FAIL wrap_m1 got vr=%0d vr1=%0d exp vr=0 vr1=1", vrender_s, vrender1_s);
        end
        checks++;
      end
    end
    if (!(seen_m1 && seen_m2)) begin
      errors++; $display("FAIL wrap_timeout got seen=%b%b exp=11", seen_m2, seen_m1);
    end
    checks++;
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 230; i++) begin
      step($urandom_range(0, 2) != 0);
      if (obs_s() !== model(ps, n, ho_s, vo_s)) begin
        errors++; $display("FAIL mid_s n=%0d got=%h exp=%h", n, obs_s(), model(ps, n, ho_s, vo_s));
      end
      checks++;
    end
    rst_n = 1'b0;
    pxl_cen = 1'b1;
    #2;
    if (obs_d() !== model(pd, 0, 0, 0)) begin
      errors++; $display("FAIL midrst_d got=%h exp=%h", obs_d(), model(pd, 0, 0, 0));
    end
    checks++;
    @(posedge clk);
    #1;
    if (obs_s() !== model(ps, 0, 0, 0)) begin
      errors++; $display("FAIL midrst_hold_s got=%h exp=%h", obs_s(), model(ps, 0, 0, 0));
    end
    checks++;
    rst_n = 1'b1;
    n = 0; ho_d = 0; vo_d = 0; ho_s = 0; vo_s = 0;
    for (int i = 0; i < 150; i++) begin
      step($urandom_range(0, 1) == 1);
      if (obs_d() !== model(pd, n, ho_d, vo_d)) begin
        errors++; $display("FAIL resume_d n=%0d got=%h exp=%h", n, obs_d(), model(pd, n, ho_d, vo_d));
      end
      checks++;
      if (obs_s() !== model(ps, n, ho_s, vo_s)) begin
        errors++; $display("FAIL resume_s n=%0d got=%h exp=%h", n, obs_s(), model(ps, n, ho_s, vo_s));
      end
      checks++;
    end
  endtask

`ifdef JTCONTRA_VTIMER_ADJ_EN
  task automatic test_adj();
    int fs;
    logic [23:0] vs0, vs1;
    logic [47:0] hs0, hs1;
    fs = ps.ht * ps.vt;
    vs0 = '0; vs1 = '0; hs0 = '0; hs1 = '0;
    hoffset = 4'h0; voffset = 4'h0;
    do_reset();
    for (int i = 0; i < 3 * fs && n < 2 * fs + 50; i++) begin
      if (n == 500) begin hoffset = 4'h8; voffset = 4'h3; end
      if (n == fs + 300) begin
        hoffset = 4'($urandom_range(0, 15)); voffset = 4'($urandom_range(0, 15));
      end
      step(1'b1);
      if (obs_s() !== model(ps, n, ho_s, vo_s)) begin
        errors++; $display("FAIL adj_s n=%0d got=%h exp=%h", n, obs_s(), model(ps, n, ho_s, vo_s));
      end
      checks++;
      if (n > 500 && n < fs) begin
        if (vs_s) vs0[int'(vdump_s)] = 1'b1;
        if (hs_s && vdump_s == 9'd15) hs0[int'(hdump_s)] = 1'b1;
      end else if (n >= fs && n < 2 * fs) begin
        if (vs_s) vs1[int'(vdump_s)] = 1'b1;
        if (hs_s && vdump_s == 9'd5) hs1[int'(hdump_s)] = 1'b1;
      end
    end
    if (n != 2 * fs + 50) begin errors++; $display("FAIL adj_timeout got n=%0d", n); end
    checks++;
    if (vs0 !== 24'hC00000 || hs0 !== 48'hF000_0000_000F) begin
      errors++; $display("FAIL adj_cur_frame got vs=%h hs=%h exp vs=%h hs=%h",
                         vs0, hs0, 24'hC00000, 48'hF000_0000_000F);
    end
    checks++;
    if (vs1 !== 24'h00001E || hs1 !== 48'h0FF0_0000_0000) begin
      errors++; $display("FAIL adj_next_frame got vs=%h hs=%h exp vs=%h hs=%h",
                         vs1, hs1, 24'h00001E, 48'h0FF0_0000_0000);
    end
    checks++;
    hoffset = 4'h0; voffset = 4'h0;
  endtask
`endif

  initial begin
    pd = '{ht: 384, hb: 256, hss: 296, hsl: 32, vt: 264, vbs: 240, vbe: 16, vss: 248, vsl: 4};
    ps = '{ht: 48, hb: 32, hss: 44, hsl: 8, vt: 24, vbs: 20, vbe: 2, vss: 22, vsl: 4};
    n = 0; ho_d = 0; vo_d = 0; ho_s = 0; vo_s = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_line();
    test_gating();
    test_frame();
    test_wrap();
    test_midreset();
`ifdef JTCONTRA_VTIMER_ADJ_EN
    test_adj();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtcontra_vtimer.md
JTCONTRA_VTIMER -- requirements
Module: jtcontra_vtimer

Interface
REQ-001 SHALL have parameter HTOTAL, default 384, meaning pixels per line; hdump counts 0..HTOTAL-1.
REQ-002 SHALL have parameter HB_START, default 256, meaning first horizontally blanked hdump value.
REQ-003 SHALL have parameter HS_START, default 296, meaning first hdump with HS active.
REQ-004 SHALL have parameter HS_LEN, default 32, meaning HS width in pixels.
REQ-005 SHALL have parameter VTOTAL, default 264, meaning lines per frame; vdump counts 0..VTOTAL-1.
REQ-006 SHALL have parameter VB_START, default 240, meaning first vertically blanked line.
REQ-007 SHALL have parameter VB_END, default 16, meaning first visible line.
REQ-008 SHALL have parameter VS_START, default 248, meaning first line with VS active.
REQ-009 SHALL have parameter VS_LEN, default 4, meaning VS height in lines.
REQ-010 SHALL have port clk  input  1  system clock; the block's only clock.
REQ-011 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-012 SHALL have port pxl_cen  input  1  pixel clock enable; all state advances only on clk edges with pxl_cen=1.
REQ-013 SHALL have port hdump  output  9  horizontal pixel counter.
REQ-014 SHALL have port vdump  output  9  line currently displayed.
REQ-015 SHALL have port vrender  output  9  line being rendered, (vdump+1) mod VTOTAL.
REQ-016 SHALL have port vrender1  output  9  line being prefetched, (vdump+2) mod VTOTAL.
REQ-017 SHALL have port LHBL  output  1  high outside horizontal blanking.
REQ-018 SHALL have port LVBL  output  1  high outside vertical blanking.
REQ-019 SHALL have port HS  output  1  horizontal sync, active-high.
REQ-020 SHALL have port VS  output  1  vertical sync, active-high.

Function
REQ-021 SHALL increment hdump by 1 on each pxl_cen; at HTOTAL-1 it wraps to 0.
REQ-022 SHALL increment vdump on the pxl_cen where hdump wraps to 0; at VTOTAL-1 it wraps to 0; vrender/vrender1 update on the same edge.
REQ-023 SHALL register every flag so that, at all times, it is consistent with the current registered hdump/vdump (zero lag).
REQ-024 SHALL drive LHBL = (hdump < HB_START).
REQ-025 SHALL drive LVBL = (vdump >= VB_END) and (vdump < VB_START).
REQ-026 SHALL drive HS = 1 for hdump in [HS_START, HS_START+HS_LEN), modulo HTOTAL.
REQ-027 SHALL drive VS = 1 for vdump in [VS_START, VS_START+VS_LEN), modulo VTOTAL; VS changes only together with a vdump change.
REQ-028 SHALL hold all outputs unchanged on clk edges with pxl_cen=0.
REQ-029 SHALL use 9-bit arithmetic with explicit modulo on all wrap sums; no output ever exceeds its TOTAL-1.

Reset
REQ-030 SHALL, while rst_n=0, force hdump=0, vdump=0, vrender=1, vrender1=2, LHBL=1, LVBL=0, HS=0, VS=0, independent of clk.
REQ-031 SHALL resume counting on the first pxl_cen after rst_n deasserts; reset mid-line or mid-frame restarts from REQ-030 values.

Configuration
REQ-032 SHALL, with JTCONTRA_VTIMER_ADJ_EN defined, add inputs hoffset[3:0] and voffset[3:0] (signed, -8..+7) shifting the HS window by hoffset pixels and the VS window by voffset lines, modulo TOTAL.
REQ-033 SHALL, with JTCONTRA_VTIMER_ADJ_EN defined, sample both offsets only on the edge where vdump and hdump both wrap to 0; blanking, counters and vrender are never shifted.
REQ-034 SHALL, without JTCONTRA_VTIMER_ADJ_EN, omit hoffset/voffset ports and place syncs exactly per REQ-026/REQ-027.

Verification
REQ-035 SHALL check reset: rst_n=0 with clk stopped -> outputs take REQ-030 values immediately.
REQ-036 SHALL check line: pxl_cen every cycle from reset -> LHBL falls at hdump=256, HS high hdump 296..327, vdump=1 at hdump wrap after 384 pixels.
REQ-037 SHALL check frame: run 264x384 pixels -> LVBL high lines 16..239, VS high lines 248..251, vdump returns to 0, vrender=1, vrender1=2 afterwards.
REQ-038 SHALL check wrap: at vdump=263 -> vrender=0, vrender1=1; at vdump=262 -> vrender1=0.
REQ-039 SHALL check enable gating: pxl_cen at 1-in-4 cycles -> outputs change only on enabled edges, same sequence as continuous case.
REQ-040 SHALL check ADJ_EN: hoffset=-8 (4'h8), voffset=+3 applied mid-frame -> current frame unchanged; next frame HS on hdump 288..319, VS on lines 251..254.
